// File: rtl/skolem_sweep_ctrl.sv
// Sweeps every (s,t) pair through an external Skolem block for (x >>u s) >s t,
// brute-forcing x when the Skolem output misses; tallies IC-true pairs and failures.
module skolem_sweep_ctrl #(
  parameter int W      = 4,
  parameter int SK_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   sk_s,
  output logic [W-1:0]   sk_t,
  input  logic [W-1:0]   sk_x,
  output logic [2*W:0]   ic_cnt,
  output logic [2*W:0]   fail_cnt,
  output logic           fail_valid,
  output logic [W-1:0]   fail_s,
  output logic [W-1:0]   fail_t,
  output logic [W-1:0]   fail_x
);

  localparam int CW = 2*W + 1;
  localparam int LW = (SK_LAT > 1) ? $clog2(SK_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(SK_LAT - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [W-1:0]  ONE_W    = W'(1);

  typedef enum logic [2:0] {
    IDLE, PRESENT, CHECK, SEARCH, NEXT, FIN
  } state_t;

  state_t        state;
  logic [LW-1:0] lat_cnt;
  logic [W-1:0]  x_cand;
  logic [W-1:0]  x_samp;

  // Logical shift already yields 0 for s >= W; compare as W-bit two's complement.
  function automatic logic pred(input logic [W-1:0] x, input logic [W-1:0] s,
                                input logic [W-1:0] t);
    logic [W-1:0] sh;
    sh = x >> s;
    return ($signed(sh) > $signed(t));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      x_cand     <= '0;
      x_samp     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sk_s       <= '0;
      sk_t       <= '0;
      ic_cnt     <= '0;
      fail_cnt   <= '0;
      fail_valid <= 1'b0;
      fail_s     <= '0;
      fail_t     <= '0;
      fail_x     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ic_cnt     <= '0;
            fail_cnt   <= '0;
            fail_valid <= 1'b0;
            fail_s     <= '0;
            fail_t     <= '0;
            fail_x     <= '0;
            sk_s       <= '0;
            sk_t       <= '0;
            lat_cnt    <= '0;
            busy       <= 1'b1;
            state      <= PRESENT;
          end
        end
        FIN: state <= IDLE;
        default: begin
          // Abort wins over any count the in-flight pair would have made.
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            case (state)
              PRESENT: begin
                if (lat_cnt == LAT_LAST) state <= CHECK;
                else lat_cnt <= lat_cnt + 1'b1;
              end
              CHECK: begin
                x_samp <= sk_x;
                if (pred(sk_x, sk_s, sk_t)) begin
                  ic_cnt <= ic_cnt + ONE_C;
                  state  <= NEXT;
                end else begin
                  x_cand <= '0;
                  state  <= SEARCH;
                end
              end
              SEARCH: begin
                if (pred(x_cand, sk_s, sk_t)) begin
                  ic_cnt   <= ic_cnt + ONE_C;
                  fail_cnt <= fail_cnt + ONE_C;
                  if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_s     <= sk_s;
                    fail_t     <= sk_t;
                    fail_x     <= x_samp;
                  end
                  state <= NEXT;
                end else if (x_cand == '1) begin
                  state <= NEXT;
                end else begin
                  x_cand <= x_cand + ONE_W;
                end
              end
              NEXT: begin
                if (sk_s == '1 && sk_t == '1) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FIN;
                end else begin
                  sk_t <= sk_t + ONE_W;
                  if (sk_t == '1) sk_s <= sk_s + ONE_W;
                  lat_cnt <= '0;
                  state   <= PRESENT;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Bench for skolem_sweep_ctrl: full sweeps against good, stuck and slow Skolem models,
// plus abort, start-while-busy and mid-sweep reset sequences.
module tb_skolem_sweep_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, abort1, start3, abort3;
  logic busy1, done1, busy3, done3;
  logic [W-1:0] s1, t1, x1, s3, t3, x3;
  logic [2*W:0] ic1, fc1, ic3, fc3;
  logic fv1, fv3;
  logic [W-1:0] fs1, ft1, fx1, fs3, ft3, fx3;
  int mode;
  int nchk = 0;
  int npass = 0;

  skolem_sweep_ctrl #(.W(W), .SK_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
    .sk_s(s1), .sk_t(t1), .sk_x(x1), .ic_cnt(ic1), .fail_cnt(fc1), .fail_valid(fv1),
    .fail_s(fs1), .fail_t(ft1), .fail_x(fx1));

  skolem_sweep_ctrl #(.W(W), .SK_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .busy(busy3), .done(done3),
    .sk_s(s3), .sk_t(t3), .sk_x(x3), .ic_cnt(ic3), .fail_cnt(fc3), .fail_valid(fv3),
    .fail_s(fs3), .fail_t(ft3), .fail_x(fx3));

  function automatic logic sat(input logic [3:0] x, input logic [3:0] s, input logic [3:0] t);
    logic [3:0] sh;
    sh = x >> s;
    return ($signed(sh) > $signed(t));
  endfunction

  function automatic logic [3:0] good_x(input logic [3:0] s, input logic [3:0] t);
    for (int i = 0; i < 16; i++)
      if (sat(4'(i), s, t)) return 4'(i);
    return 4'd0;
  endfunction

  always_comb begin
    x1 = good_x(s1, t1);
    case (mode)
      1: x1 = 4'd0;
      2: x1 = 4'd7;
      default: ;
    endcase
  end

  // Slow Skolem: correct only once operands have been stable for 3 edges.
  logic [7:0] d1 = '0, d2 = '0, d3 = '0;
  always @(posedge clk) begin
    d1 <= {s3, t3};
    d2 <= d1;
    d3 <= d2;
  end
  assign x3 = (d1 == {s3, t3} && d2 == {s3, t3} && d3 == {s3, t3}) ? good_x(s3, t3) : 4'h8;

  typedef struct {
    int mode;
    bit l3;
    int ic;
    int fc;
    int fv;
    int fs;
    int ft;
    int fx;
    int cyc;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run_sweep(input vec_t v, input bit with_abort, input string tag);
    int cyc;
    bit dn;
    mode = v.mode;
    @(negedge clk);
    if (v.l3) start3 = 1'b1; else start1 = 1'b1;
    abort1 = with_abort;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0; abort1 = 1'b0;
    cyc = 1;
    check({tag, " busy after start"}, int'(v.l3 ? busy3 : busy1), 1);
    dn = v.l3 ? done3 : done1;
    while (!dn && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      dn = v.l3 ? done3 : done1;
    end
    check({tag, " done seen"}, int'(dn), 1);
    if (v.cyc != 0) check({tag, " cycles to done"}, cyc, v.cyc);
    check({tag, " busy at done"}, int'(v.l3 ? busy3 : busy1), 0);
    check({tag, " ic_cnt"}, v.l3 ? int'(ic3) : int'(ic1), v.ic);
    check({tag, " fail_cnt"}, v.l3 ? int'(fc3) : int'(fc1), v.fc);
    check({tag, " fail_valid"}, int'(v.l3 ? fv3 : fv1), v.fv);
    check({tag, " fail_s"}, v.l3 ? int'(fs3) : int'(fs1), v.fs);
    check({tag, " fail_t"}, v.l3 ? int'(ft3) : int'(ft1), v.ft);
    check({tag, " fail_x"}, v.l3 ? int'(fx3) : int'(fx1), v.fx);
    @(negedge clk);
    check({tag, " done one cycle"}, int'(v.l3 ? done3 : done1), 0);
  endtask

  initial begin
    bit saw;
    vecs[0] = '{0, 1'b0, 146, 0,  0, 0, 0, 0, 2529};
    vecs[1] = '{1, 1'b0, 146, 18, 1, 0, 0, 0, 0};
    vecs[2] = '{2, 1'b0, 146, 7,  1, 1, 3, 7, 0};
    vecs[3] = '{0, 1'b1, 146, 0,  0, 0, 0, 0, 3041};

    mode = 0;
    rst = 1'b1; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", int'(busy1), 0);
    check("reset done", int'(done1), 0);
    check("reset ic_cnt", int'(ic1), 0);
    check("reset fail_cnt", int'(fc1), 0);
    check("reset fail_valid", int'(fv1), 0);
    check("reset sk_s", int'(s1), 0);
    check("reset sk_t", int'(t1), 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run_sweep(vecs[i], 1'b0, $sformatf("v%0d", i));

    // Abort at the CHECK of pair (0,6): six pairs counted; the start at cycle 10 is ignored.
    mode = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      start1 = (c == 10);
      abort1 = (c == 20);
    end
    @(negedge clk);
    abort1 = 1'b0;
    check("abort done", int'(done1), 1);
    check("abort busy", int'(busy1), 0);
    check("abort ic_cnt", int'(ic1), 6);
    check("abort fail_cnt", int'(fc1), 0);
    @(negedge clk);
    check("abort done one cycle", int'(done1), 0);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    check("idle abort no done", int'(done1), 0);
    check("idle abort busy", int'(busy1), 0);
    check("results hold ic_cnt", int'(ic1), 6);

    // Mid-sweep reset.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst busy", int'(busy1), 0);
    check("rst done", int'(done1), 0);
    check("rst ic_cnt", int'(ic1), 0);
    check("rst fail_cnt", int'(fc1), 0);
    check("rst fail_valid", int'(fv1), 0);
    rst = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done1) saw = 1'b1;
    end
    check("rst no done pulse", int'(saw), 0);

    // Start and abort together in IDLE: start wins, full sweep.
    run_sweep(vecs[0], 1'b1, "post-rst");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
